// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register: load-use bubble, flush, backpressure hold with WB operand patch
// Optional stall statistics counters enabled by defining STALL_STAT_EN.
module id_ex_stage #(
    parameter int          XLEN     = 32,
    parameter logic [31:0] NOP_INST = 32'h00000013
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [31:0]     id_inst,
    input  logic [31:0]     id_inst_addr,
    input  logic [4:0]      id_rs1_addr,
    input  logic [4:0]      id_rs2_addr,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [4:0]      id_rd_addr,
    input  logic            id_rd_wen,
    input  logic            id_is_load,
    input  logic            flush,
    input  logic            ex_ready,
    input  logic [4:0]      wb_rd_addr,
    input  logic [XLEN-1:0] wb_rd_data,
    input  logic            wb_rd_wen,
    output logic            id_ready,
    output logic            ex_valid,
    output logic [31:0]     ex_inst,
    output logic [31:0]     ex_inst_addr,
    output logic [XLEN-1:0] ex_op1,
    output logic [XLEN-1:0] ex_op2,
    output logic [4:0]      ex_rd_addr,
    output logic            ex_rd_wen,
    output logic            ex_is_load,
    output logic [31:0]     stat_bubble_cnt,
    output logic [31:0]     stat_flush_cnt
);

    // Source indices of the held instruction, needed to patch operands while stalled
    logic [4:0] ex_rs1_addr;
    logic [4:0] ex_rs2_addr;

    logic load_in_ex;
    logic rs1_dep;
    logic rs2_dep;
    logic hazard;
    logic patch_op1;
    logic patch_op2;
    logic bubble_fire;

    assign load_in_ex  = ex_valid & ex_is_load & ex_rd_wen & (ex_rd_addr != 5'd0);
    assign rs1_dep     = (id_rs1_addr == ex_rd_addr) & (id_rs1_addr != 5'd0);
    assign rs2_dep     = (id_rs2_addr == ex_rd_addr) & (id_rs2_addr != 5'd0);
    assign hazard      = load_in_ex & id_valid & (rs1_dep | rs2_dep);
    assign id_ready    = flush | (ex_ready & ~hazard);
    assign bubble_fire = ~flush & ex_ready & hazard;

    assign patch_op1 = wb_rd_wen & (wb_rd_addr != 5'd0) & (wb_rd_addr == ex_rs1_addr);
    assign patch_op2 = wb_rd_wen & (wb_rd_addr != 5'd0) & (wb_rd_addr == ex_rs2_addr);

    always_ff @(posedge clk) begin
        if (rst || flush || bubble_fire) begin
            ex_valid     <= 1'b0;
            ex_inst      <= NOP_INST;
            ex_inst_addr <= '0;
            ex_op1       <= '0;
            ex_op2       <= '0;
            ex_rd_addr   <= '0;
            ex_rd_wen    <= 1'b0;
            ex_is_load   <= 1'b0;
            ex_rs1_addr  <= '0;
            ex_rs2_addr  <= '0;
        end else if (!ex_ready) begin
            if (patch_op1) ex_op1 <= wb_rd_data;
            if (patch_op2) ex_op2 <= wb_rd_data;
        end else begin
            ex_valid     <= id_valid;
            ex_inst      <= id_valid ? id_inst : NOP_INST;
            ex_inst_addr <= id_inst_addr;
            ex_op1       <= id_rs1_data;
            ex_op2       <= id_rs2_data;
            ex_rd_addr   <= id_rd_addr;
            ex_rd_wen    <= id_valid & id_rd_wen;
            ex_is_load   <= id_valid & id_is_load;
            ex_rs1_addr  <= id_rs1_addr;
            ex_rs2_addr  <= id_rs2_addr;
        end
    end

`ifdef STALL_STAT_EN
    logic [31:0] bubble_cnt;
    logic [31:0] flush_cnt;

    // Counters stick at all-ones rather than wrapping
    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt <= '0;
            flush_cnt  <= '0;
        end else begin
            if (bubble_fire && (bubble_cnt != 32'hFFFF_FFFF)) bubble_cnt <= bubble_cnt + 32'd1;
            if (flush && (flush_cnt != 32'hFFFF_FFFF))        flush_cnt  <= flush_cnt + 32'd1;
        end
    end

    assign stat_bubble_cnt = bubble_cnt;
    assign stat_flush_cnt  = flush_cnt;
`else
    assign stat_bubble_cnt = '0;
    assign stat_flush_cnt  = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed table plus randomized check of id_ex_stage against a slot-level reference model
module tb_id_ex_stage;

    localparam logic [31:0] NOP   = 32'h00000013;
    localparam logic [31:0] LW    = 32'h0000a283;
    localparam logic [31:0] LW0   = 32'h0000a003;
    localparam logic [31:0] ADD   = 32'h00128333;
    localparam logic [31:0] ADDI7 = 32'h00500393;
    localparam logic [31:0] ADDI5 = 32'h00508293;
    localparam logic [31:0] ADDI6 = 32'h00528313;
    localparam logic [31:0] ADD8  = 32'h00708433;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_inst, id_inst_addr;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic [31:0] id_rs1_data, id_rs2_data;
    logic        id_rd_wen, id_is_load, flush, ex_ready;
    logic [4:0]  wb_rd_addr;
    logic [31:0] wb_rd_data;
    logic        wb_rd_wen;
    logic        id_ready, ex_valid, ex_rd_wen, ex_is_load;
    logic [31:0] ex_inst, ex_inst_addr, ex_op1, ex_op2;
    logic [4:0]  ex_rd_addr;
    logic [31:0] stat_bubble_cnt, stat_flush_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_inst(id_inst), .id_inst_addr(id_inst_addr),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rs1_data(id_rs1_data),
        .id_rs2_data(id_rs2_data), .id_rd_addr(id_rd_addr), .id_rd_wen(id_rd_wen),
        .id_is_load(id_is_load), .flush(flush), .ex_ready(ex_ready), .wb_rd_addr(wb_rd_addr),
        .wb_rd_data(wb_rd_data), .wb_rd_wen(wb_rd_wen), .id_ready(id_ready), .ex_valid(ex_valid),
        .ex_inst(ex_inst), .ex_inst_addr(ex_inst_addr), .ex_op1(ex_op1), .ex_op2(ex_op2),
        .ex_rd_addr(ex_rd_addr), .ex_rd_wen(ex_rd_wen), .ex_is_load(ex_is_load),
        .stat_bubble_cnt(stat_bubble_cnt), .stat_flush_cnt(stat_flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, flush, exr, vld;
        logic [31:0] inst;
        logic [4:0]  rs1, rs2, rd;
        logic        wen, ld;
        logic [31:0] d1, d2;
        logic        wbw;
        logic [4:0]  wba;
        logic [31:0] wbd;
        logic        e_ready, e_valid;
        logic [31:0] e_inst, e_op1, e_op2;
        logic        e_wen, e_ld;
    } vec_t;

    typedef struct {
        logic        v;
        logic [31:0] inst, pc, op1, op2;
        logic [4:0]  rd, rs1, rs2;
        logic        wen, ld;
    } slot_t;

    vec_t tbl[$];

    function automatic vec_t mk(input int r, f, x, v, input logic [31:0] inst, input int rs1, rs2, rd, wen, ld,
                                input logic [31:0] d1, d2, input int wbw, wba, input logic [31:0] wbd,
                                input int er, ev, input logic [31:0] ei, eo1, eo2, input int ew, el);
        vec_t t;
        t.rst = r[0]; t.flush = f[0]; t.exr = x[0]; t.vld = v[0]; t.inst = inst;
        t.rs1 = rs1[4:0]; t.rs2 = rs2[4:0]; t.rd = rd[4:0]; t.wen = wen[0]; t.ld = ld[0];
        t.d1 = d1; t.d2 = d2; t.wbw = wbw[0]; t.wba = wba[4:0]; t.wbd = wbd;
        t.e_ready = er[0]; t.e_valid = ev[0]; t.e_inst = ei; t.e_op1 = eo1; t.e_op2 = eo2;
        t.e_wen = ew[0]; t.e_ld = el[0];
        return t;
    endfunction

    function automatic slot_t empty_slot();
        slot_t s;
        s.v = 1'b0; s.inst = NOP; s.pc = '0; s.op1 = '0; s.op2 = '0;
        s.rd = '0; s.rs1 = '0; s.rs2 = '0; s.wen = 1'b0; s.ld = 1'b0;
        return s;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t t, input int idx);
        rst = t.rst; flush = t.flush; ex_ready = t.exr; id_valid = t.vld; id_inst = t.inst;
        id_inst_addr = 32'h80 + 32'(idx) * 4; id_rs1_addr = t.rs1; id_rs2_addr = t.rs2;
        id_rd_addr = t.rd; id_rd_wen = t.wen; id_is_load = t.ld; id_rs1_data = t.d1; id_rs2_data = t.d2;
        wb_rd_wen = t.wbw; wb_rd_addr = t.wba; wb_rd_data = t.wbd;
    endtask

    task automatic run_row(input int i);
        @(negedge clk);
        drive(tbl[i], i);
        #1 chk($sformatf("r%0d id_ready", i), 32'(id_ready), 32'(tbl[i].e_ready));
        @(posedge clk);
        #1;
        chk($sformatf("r%0d ex_valid", i), 32'(ex_valid), 32'(tbl[i].e_valid));
        chk($sformatf("r%0d ex_inst", i), ex_inst, tbl[i].e_inst);
        chk($sformatf("r%0d ex_op1", i), ex_op1, tbl[i].e_op1);
        chk($sformatf("r%0d ex_op2", i), ex_op2, tbl[i].e_op2);
        chk($sformatf("r%0d ex_rd_wen", i), 32'(ex_rd_wen), 32'(tbl[i].e_wen));
        chk($sformatf("r%0d ex_is_load", i), 32'(ex_is_load), 32'(tbl[i].e_ld));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        slot_t       m;
        logic [31:0] mb, mf;
        logic        stall, exp_rdy;
        int          exp_b, exp_f;

        //      r f x v  inst  rs1 rs2 rd w l  d1        d2        wbw wba wbd            er ev inst   op1        op2           w l
        tbl.push_back(mk(0,0,1,1, LW,    1,0,5,1,1, 'h100,   0,       0,0,0,             1, 1,LW,   'h100,     0,            1,1));
        tbl.push_back(mk(0,0,1,1, ADD,   5,1,6,1,0, 'h111,   'h100,   0,0,0,             0, 0,NOP,  0,         0,            0,0));
        tbl.push_back(mk(0,0,1,1, ADD,   5,1,6,1,0, 'h55,    'h100,   1,5,'h55,          1, 1,ADD,  'h55,      'h100,        1,0));
        tbl.push_back(mk(0,0,1,1, LW0,   1,0,0,1,1, 7,       0,       0,0,0,             1, 1,LW0,  7,         0,            1,1));
        tbl.push_back(mk(0,0,1,1, ADDI7, 0,0,7,1,0, 0,       0,       0,0,0,             1, 1,ADDI7,0,         0,            1,0));
        tbl.push_back(mk(0,0,1,1, ADDI5, 1,0,5,1,0, 9,       0,       0,0,0,             1, 1,ADDI5,9,         0,            1,0));
        tbl.push_back(mk(0,0,1,1, ADDI6, 5,0,6,1,0, 'h1234,  0,       0,0,0,             1, 1,ADDI6,'h1234,    0,            1,0));
        tbl.push_back(mk(0,0,1,1, ADD8,  1,7,8,1,0, 'h11,    'h22,    0,0,0,             1, 1,ADD8, 'h11,      'h22,         1,0));
        tbl.push_back(mk(0,0,0,1, ADD,   5,1,6,1,0, 3,       4,       1,7,32'hDEADBEEF,  0, 1,ADD8, 'h11,      32'hDEADBEEF, 1,0));
        tbl.push_back(mk(0,0,0,1, ADD,   5,1,6,1,0, 3,       4,       1,1,'hCAFE,        0, 1,ADD8, 'hCAFE,    32'hDEADBEEF, 1,0));
        tbl.push_back(mk(0,0,0,1, ADD,   5,1,6,1,0, 3,       4,       1,0,'hFFFF,        0, 1,ADD8, 'hCAFE,    32'hDEADBEEF, 1,0));
        tbl.push_back(mk(0,0,1,1, LW,    1,0,5,1,1, 'h100,   0,       0,0,0,             1, 1,LW,   'h100,     0,            1,1));
        tbl.push_back(mk(0,1,0,1, ADD,   5,1,6,1,0, 'h111,   'h100,   0,0,0,             1, 0,NOP,  0,         0,            0,0));
        tbl.push_back(mk(0,0,1,1, ADD,   5,1,6,1,0, 'h77,    'h100,   0,0,0,             1, 1,ADD,  'h77,      'h100,        1,0));
        tbl.push_back(mk(0,0,1,0, ADD,   5,1,6,1,1, 0,       0,       0,0,0,             1, 0,NOP,  0,         0,            0,0));
        tbl.push_back(mk(0,0,1,1, LW,    1,0,5,1,1, 'h100,   0,       0,0,0,             1, 1,LW,   'h100,     0,            1,1));
        tbl.push_back(mk(0,0,1,1, ADD,   1,5,6,1,0, 'h100,   'h111,   0,0,0,             0, 0,NOP,  0,         0,            0,0));
        tbl.push_back(mk(0,0,1,1, ADD,   1,5,6,1,0, 'h100,   5,       0,0,0,             1, 1,ADD,  'h100,     5,            1,0));
        tbl.push_back(mk(0,0,1,1, LW,    1,0,5,1,1, 'h100,   0,       0,0,0,             1, 1,LW,   'h100,     0,            1,1));
        tbl.push_back(mk(0,0,1,1, ADD,   5,1,6,1,0, 'h111,   'h100,   0,0,0,             0, 0,NOP,  0,         0,            0,0));
        tbl.push_back(mk(0,0,1,1, ADD,   5,1,6,1,0, 6,       'h100,   0,0,0,             1, 1,ADD,  6,         'h100,        1,0));
        tbl.push_back(mk(0,1,1,0, ADD,   5,1,6,1,0, 0,       0,       0,0,0,             1, 0,NOP,  0,         0,            0,0));
        tbl.push_back(mk(0,0,1,1, LW,    1,0,5,1,1, 'h100,   0,       0,0,0,             1, 1,LW,   'h100,     0,            1,1));
        tbl.push_back(mk(1,0,1,1, ADD,   5,1,6,1,0, 'h111,   'h100,   0,0,0,             0, 0,NOP,  0,         0,            0,0));
        tbl.push_back(mk(0,0,1,0, ADD,   0,0,0,0,0, 0,       0,       0,0,0,             1, 0,NOP,  0,         0,            0,0));

        // Reset while ID holds a valid instruction
        drive(tbl[0], 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("reset ex_valid", 32'(ex_valid), 32'd0);
        chk("reset ex_inst", ex_inst, NOP);
        chk("reset ex_op1", ex_op1, 32'd0);
        chk("reset ex_rd_wen", 32'(ex_rd_wen), 32'd0);
        chk("reset stat_bubble", stat_bubble_cnt, 32'd0);
        chk("reset stat_flush", stat_flush_cnt, 32'd0);

        for (int i = 0; i < 22; i++) run_row(i);
`ifdef STALL_STAT_EN
        exp_b = 3; exp_f = 2;
`else
        exp_b = 0; exp_f = 0;
`endif
        chk("stat_bubble after 3 hazards", stat_bubble_cnt, 32'(exp_b));
        chk("stat_flush after 2 flushes", stat_flush_cnt, 32'(exp_f));
        for (int i = 22; i < tbl.size(); i++) run_row(i);
        chk("stat_bubble after reset", stat_bubble_cnt, 32'd0);
        chk("stat_flush after reset", stat_flush_cnt, 32'd0);

        // Randomized traffic against the slot model
        m = empty_slot();
        mb = '0;
        mf = '0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst          = ($urandom_range(63) == 0);
            flush        = ($urandom_range(9) == 0);
            ex_ready     = ($urandom_range(3) != 0);
            id_valid     = ($urandom_range(4) != 0);
            id_inst      = $urandom;
            id_inst_addr = $urandom;
            id_rs1_addr  = 5'($urandom_range(7));
            id_rs2_addr  = 5'($urandom_range(7));
            id_rd_addr   = 5'($urandom_range(7));
            id_rd_wen    = ($urandom_range(5) != 0);
            id_is_load   = ($urandom_range(2) == 0);
            id_rs1_data  = $urandom;
            id_rs2_data  = $urandom;
            wb_rd_wen    = ($urandom_range(1) == 0);
            wb_rd_addr   = 5'($urandom_range(7));
            wb_rd_data   = $urandom;

            stall = m.v && m.ld && m.wen && (m.rd != 0) && id_valid &&
                    ((id_rs1_addr == m.rd && id_rs1_addr != 0) || (id_rs2_addr == m.rd && id_rs2_addr != 0));
            exp_rdy = flush || (ex_ready && !stall);
            #1 chk($sformatf("rand%0d id_ready", c), 32'(id_ready), 32'(exp_rdy));

            @(posedge clk);
            if (rst) begin
                m = empty_slot(); mb = '0; mf = '0;
            end else if (flush) begin
                m = empty_slot();
                if (mf != 32'hFFFF_FFFF) mf = mf + 1;
            end else if (!ex_ready) begin
                if (wb_rd_wen && wb_rd_addr != 0 && wb_rd_addr == m.rs1) m.op1 = wb_rd_data;
                if (wb_rd_wen && wb_rd_addr != 0 && wb_rd_addr == m.rs2) m.op2 = wb_rd_data;
            end else if (stall) begin
                m = empty_slot();
                if (mb != 32'hFFFF_FFFF) mb = mb + 1;
            end else begin
                m.v = id_valid; m.inst = id_valid ? id_inst : NOP; m.pc = id_inst_addr;
                m.op1 = id_rs1_data; m.op2 = id_rs2_data; m.rd = id_rd_addr;
                m.rs1 = id_rs1_addr; m.rs2 = id_rs2_addr;
                m.wen = id_valid && id_rd_wen; m.ld = id_valid && id_is_load;
            end
            #1;
            chk($sformatf("rand%0d ex_valid", c), 32'(ex_valid), 32'(m.v));
            chk($sformatf("rand%0d ex_inst", c), ex_inst, m.inst);
            chk($sformatf("rand%0d ex_rd_wen", c), 32'(ex_rd_wen), 32'(m.wen));
            chk($sformatf("rand%0d ex_is_load", c), 32'(ex_is_load), 32'(m.ld));
            if (m.v) begin
                chk($sformatf("rand%0d ex_inst_addr", c), ex_inst_addr, m.pc);
                chk($sformatf("rand%0d ex_op1", c), ex_op1, m.op1);
                chk($sformatf("rand%0d ex_op2", c), ex_op2, m.op2);
                chk($sformatf("rand%0d ex_rd_addr", c), 32'(ex_rd_addr), 32'(m.rd));
            end
        end
`ifndef STALL_STAT_EN
        mb = '0;
        mf = '0;
`endif
        chk("rand stat_bubble", stat_bubble_cnt, mb);
        chk("rand stat_flush", stat_flush_cnt, mf);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
